ibex_csr_shadow: RTL and testbench
==================================

Name: ibex_csr_shadow

Overview:
- Single control/status register with optional shadow copy for fault detection; one instance per protected CSR in the core's CSR file.
- Holds a Width-bit value that is written on a write-enable strobe and is always readable.
- When ShadowCopy is enabled, an inverted duplicate is stored alongside. Any mismatch between the two is flagged on rd_error_o.

Parameters:
- Width, 32, register width in bits (≥1).
- ShadowCopy, 1'b0, 1 = instantiate inverted shadow register and mismatch check; 0 = no shadow, rd_error_o tied 0.
- ResetValue, '0 (Width bits), value loaded into the main register on reset.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- wr_data_i  input  Width  write data.
- wr_en_i  input  1  write strobe; sampled on rising clk_i.
- rd_data_o  output  Width  current main register value.
- rd_error_o  output  1  shadow mismatch flag.

Behaviour:
- Main register rdata_q, at each rising clk_i:
  - rst_i=1 -> ResetValue.
  - else wr_en_i=1 -> wr_data_i.
  - else hold.
- Reset has priority over write: a write in the same cycle as reset is discarded.
- rd_data_o = rdata_q, driven combinationally from the flop with no extra logic.
- Write latency is 1 cycle: data written at edge N is visible on rd_data_o after edge N and stays stable until the next write or reset.
- Shadow register shadow_q (ShadowCopy=1 only), at each rising clk_i:
  - rst_i=1 -> ~ResetValue.
  - else wr_en_i=1 -> ~wr_data_i.
  - else hold.
- rd_error_o, ShadowCopy=1: combinational, = (rdata_q != ~shadow_q). It is 0 in every fault-free state, including immediately after reset and after every write.
- rd_error_o, ShadowCopy=0: constant 0; no shadow flops generated.
- Error flag is not sticky. A fault that corrupts one copy asserts rd_error_o until a write or reset resynchronises both copies.
- Before the first reset edge the outputs are undefined. Reset must be applied for ≥1 clock edge before use.
- Any bit pattern of wr_data_i is legal, including all-0 and all-1. No width conversion or masking is applied.
- Reset mid-operation: the next edge with rst_i=1 forces ResetValue / ~ResetValue regardless of prior contents.
- Back-to-back writes on consecutive cycles: each one overwrites; the last write wins.
- The main and shadow registers must be kept as separate flops. Synthesis must not merge them (keep/preserve attributes per team flow).

Test Plan:
- Reset: hold rst_i=1 for 1 edge with ResetValue=0 -> rd_data_o=0x00000000, rd_error_o=0.
- Basic write: rst_i=0, wr_data_i=0x01010101, wr_en_i=1 for 1 cycle, then wr_en_i=0 and wr_data_i=0 -> rd_data_o=0x01010101 after the edge, held while wr_en_i=0; rd_error_o=0.
- Write/reset sweep: repeat the write-then-reset pattern for values 0x01010101, 0x02020202 … 0x63636363 (step 0x01010101). Each write must read back exactly, and each following reset must return rd_data_o to 0. rd_error_o=0 throughout.
- Reset/write collision: rst_i=1 and wr_en_i=1 with wr_data_i=0xDEADBEEF on the same edge -> rd_data_o=ResetValue.
- Fault injection (ShadowCopy=1): after writing 0x12345678, force one shadow bit to flip -> rd_error_o=1 with rd_data_o unchanged. A subsequent write of 0xA5A5A5A5 -> rd_error_o=0.
- ShadowCopy=0 build: same write sweep -> identical rd_data_o; rd_error_o constantly 0.

Source files
------------

// File: rtl/ibex_csr_shadow.sv
`default_nettype none
// ============================================================================
// Module   : ibex_csr_shadow
// Purpose  : Single CSR with an optional inverted shadow copy for fault detection.
// Revision : 1.0 - initial release
// ============================================================================

module ibex_csr_shadow #(
   parameter int unsigned      WIDTH       = 32,
   parameter bit               SHADOW_COPY = 1'b0,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             wr_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             rd_error_o
);

   (* keep = "true" *) logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rdata <= RESET_VALUE;
      end else if (wr_en_i) begin
         r_rdata <= wr_data_i;
      end
   end

   assign rd_data_o = r_rdata;

   generate
      if (SHADOW_COPY) begin : g_shadow
         // Stored inverted so a stuck-at or common-mode upset cannot hit both copies alike.
         (* keep = "true" *) logic [WIDTH-1:0] r_shadow;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_shadow <= ~RESET_VALUE;
            end else if (wr_en_i) begin
               r_shadow <= ~wr_data_i;
            end
         end

         assign rd_error_o = (r_rdata != ~r_shadow);
      end else begin : g_no_shadow
         assign rd_error_o = 1'b0;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_ibex_csr_shadow.sv
`default_nettype none
// Testbench for ibex_csr_shadow: shadowed and unshadowed instances driven in
// lockstep, checked against a register model.

module tb_ibex_csr_shadow;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = '0;
   logic [31:0] rdata_s, rdata_n;
   logic        err_s, err_n;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] model;

   always #5 clk = ~clk;

   ibex_csr_shadow #(.WIDTH(32), .SHADOW_COPY(1'b1), .RESET_VALUE(32'h0)) u_dut_s (
      .clk_i(clk), .rst_i(rst), .wr_data_i(wr_data), .wr_en_i(wr_en),
      .rd_data_o(rdata_s), .rd_error_o(err_s)
   );

   ibex_csr_shadow #(.WIDTH(32), .SHADOW_COPY(1'b0), .RESET_VALUE(32'h0)) u_dut_n (
      .clk_i(clk), .rst_i(rst), .wr_data_i(wr_data), .wr_en_i(wr_en),
      .rd_data_o(rdata_n), .rd_error_o(err_n)
   );

   typedef struct {
      logic        rst;
      logic        en;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample both instances 1 time unit after the edge.
   task automatic step(input logic r, input logic e, input logic [31:0] d);
      rst     = r;
      wr_en   = e;
      wr_data = d;
      if (r)      model = 32'h0;
      else if (e) model = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag);
      chk({tag, " rdata_s"}, rdata_s, model);
      chk({tag, " rdata_n"}, rdata_n, model);
      chk({tag, " err_s"}, {31'b0, err_s}, 32'h0);
      chk({tag, " err_n"}, {31'b0, err_n}, 32'h0);
   endtask

   initial begin
      tbl[0] = '{rst: 1'b1, en: 1'b0, data: 32'h0000_0000, exp: 32'h0000_0000};
      tbl[1] = '{rst: 1'b0, en: 1'b1, data: 32'h0101_0101, exp: 32'h0101_0101};
      tbl[2] = '{rst: 1'b0, en: 1'b0, data: 32'h0000_0000, exp: 32'h0101_0101};
      tbl[3] = '{rst: 1'b0, en: 1'b0, data: 32'hFFFF_FFFF, exp: 32'h0101_0101};
      tbl[4] = '{rst: 1'b1, en: 1'b1, data: 32'hDEAD_BEEF, exp: 32'h0000_0000};
      tbl[5] = '{rst: 1'b0, en: 1'b1, data: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFF};
      tbl[6] = '{rst: 1'b0, en: 1'b1, data: 32'h0000_0000, exp: 32'h0000_0000};
      tbl[7] = '{rst: 1'b0, en: 1'b1, data: 32'h8000_0001, exp: 32'h8000_0001};
      tbl[8] = '{rst: 1'b1, en: 1'b0, data: 32'h1234_5678, exp: 32'h0000_0000};

      model = 32'h0;
      @(negedge clk);

      foreach (tbl[i]) begin
         rst     = tbl[i].rst;
         wr_en   = tbl[i].en;
         wr_data = tbl[i].data;
         @(posedge clk);
         #1;
         model = tbl[i].exp;
         chk($sformatf("tbl%0d rdata_s", i), rdata_s, tbl[i].exp);
         chk($sformatf("tbl%0d rdata_n", i), rdata_n, tbl[i].exp);
         chk($sformatf("tbl%0d err_s", i), {31'b0, err_s}, 32'h0);
         chk($sformatf("tbl%0d err_n", i), {31'b0, err_n}, 32'h0);
      end

      // Write-then-reset sweep over 0x01010101 .. 0x63636363.
      for (int k = 1; k <= 8'h63; k++) begin
         step(1'b0, 1'b1, 32'(k) * 32'h0101_0101);
         check_all($sformatf("sweep_wr%0d", k));
         step(1'b1, 1'b0, 32'h0);
         check_all($sformatf("sweep_rst%0d", k));
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic        r, e;
         logic [31:0] d;
         r = ($urandom_range(15) == 0);
         e = ($urandom_range(1) == 1);
         case ($urandom_range(7))
            0:       d = 32'h0;
            1:       d = 32'hFFFF_FFFF;
            default: d = $urandom;
         endcase
         step(r, e, d);
         check_all($sformatf("rand%0d", i));
      end

      // Shadow fault injection: flip one shadow bit, then resync by write.
      step(1'b0, 1'b1, 32'h1234_5678);
      check_all("fi_pre");
      force u_dut_s.g_shadow.r_shadow = ~32'h1234_5678 ^ 32'h0000_0100;
      #1;
      chk("fi_err", {31'b0, err_s}, 32'h1);
      chk("fi_rdata", rdata_s, 32'h1234_5678);
      step(1'b0, 1'b0, 32'h0);
      chk("fi_err_hold", {31'b0, err_s}, 32'h1);
      chk("fi_rdata_hold", rdata_s, 32'h1234_5678);
      chk("fi_err_n", {31'b0, err_n}, 32'h0);
      release u_dut_s.g_shadow.r_shadow;
      step(1'b0, 1'b1, 32'hA5A5_A5A5);
      check_all("fi_resync_wr");

      // Same fault, cleared by reset instead of a write.
      force u_dut_s.g_shadow.r_shadow = ~32'hA5A5_A5A5 ^ 32'h8000_0000;
      #1;
      chk("fi2_err", {31'b0, err_s}, 32'h1);
      release u_dut_s.g_shadow.r_shadow;
      step(1'b1, 1'b0, 32'h0);
      check_all("fi2_resync_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
